// File: rtl/commit_trace_wb.sv
// rtl/commit_trace_wb.sv - Commit tracer streaming one 4-word record per retired instruction to memory over Wishbone
module commit_trace_wb #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
    parameter int          BUF_RECORDS = 256,
    parameter int          FIFO_DEPTH  = 4,
    localparam int         IDX_W       = $clog2(BUF_RECORDS),
    localparam int         PTR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              post_execution,
    input  logic [31:0]       pc_debug,
    input  logic [31:0][31:0] debug_registers,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [31:0]       wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic [31:0]       commit_count,
    output logic [15:0]       drop_count,
    output logic [IDX_W-1:0]  wr_index,
    output logic              overflow,
    output logic              bus_error
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t           state, state_nxt;
    logic [1:0]       word, word_nxt;
    logic             pe_q;
    logic [127:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             commit, fifo_full, fifo_empty;
    logic             push, pop, drop;
    logic             last_ack, err_hit;
    logic [31:0]      reg_xor;
    logic [127:0]     record, head;

    assign commit     = post_execution & ~pe_q & enable;
    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // A pop in the same cycle frees the slot, so a commit into a full FIFO still lands
    assign push       = commit & (~fifo_full | pop);
    assign drop       = commit & fifo_full & ~pop;

    always_comb begin
        reg_xor = '0;
        for (int i = 1; i < 32; i++) begin
            reg_xor = reg_xor ^ debug_registers[i];
        end
    end

    // word0 occupies the low 32 bits so the bus word index selects directly
    assign record = {drop_count, 16'hC0DE, reg_xor, commit_count, pc_debug};
    assign head   = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        pop       = 1'b0;
        last_ack  = 1'b0;
        err_hit   = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_adr_o  = '0;
        wb_dat_o  = '0;
        wb_sel_o  = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = XFER;
                    word_nxt  = 2'd0;
                end
            end
            XFER: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_sel_o = 4'hF;
                wb_adr_o = BASE_ADDR + 32'({wr_index, 4'b0000}) + 32'({word, 2'b00});
                wb_dat_o = head[{word, 5'b00000} +: 32];
                if (wb_err_i) begin
                    err_hit   = 1'b1;
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end else if (wb_ack_i) begin
                    word_nxt = word + 2'd1;
                    if (word == 2'd3) begin
                        last_ack  = 1'b1;
                        pop       = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            word         <= 2'd0;
            pe_q         <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_cnt     <= '0;
            commit_count <= '0;
            drop_count   <= '0;
            wr_index     <= '0;
            overflow     <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            state <= state_nxt;
            word  <= word_nxt;
            pe_q  <= post_execution;
            if (commit) begin
                commit_count <= commit_count + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            // An errored record is abandoned without consuming a buffer slot
            if (last_ack) begin
                wr_index <= wr_index + IDX_W'(1);
            end
            if (err_hit) begin
                bus_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= record;
        end
    end

endmodule
